ram8_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 8x16 ram8 store. Each requester issues one read or write at a time over a req/ack handshake. The arbiter serialises access, drives ram8's data, address and load inputs, and returns read data. It sits between the two datapath clients and the single ram8 instance.

---
 rtl/ram8_arbiter_pkg.sv | 6 +
 rtl/ram8_arbiter_if.sv | 24 ++
 rtl/ram8.sv | 16 +
 rtl/ram8_arbiter_rr_pick2.sv | 11 +
 rtl/ram8_arbiter.sv | 56 +++++
 tb/tb_ram8_arbiter.sv | 177 +++++++++++++++++
 6 files changed

// File: rtl/ram8_arbiter_pkg.sv
// ram8_arbiter_pkg: shared state encoding and default widths for the ram8 arbiter
package ram8_arbiter_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2} state_t;
endpackage

// File: rtl/ram8_arbiter_if.sv
// ram8_arbiter_if: two-requester req/ack handshake bundle plus arbiter status
interface ram8_arbiter_if
  import ram8_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              req0, we0, ack0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              req1, we1, ack1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic [DATA_W-1:0] rdata;
  logic              busy, gnt_id;
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
    input  ack0, ack1, rdata, busy, gnt_id
  );
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
    output ack0, ack1, rdata, busy, gnt_id
  );
endinterface

// File: rtl/ram8.sv
// ram8: 8x16 store, synchronous write on load, combinational read at addr
module ram8 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              load,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (load) mem[addr] <= data;
  assign q = mem[addr];
endmodule

// File: rtl/ram8_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker, ptr breaks ties
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic valid,
  output logic winner
);
  assign valid  = req0 | req1;
  assign winner = (req0 & req1) ? ptr : req1;
endmodule

// File: rtl/ram8_arbiter.sv
// ram8_arbiter: round-robin sequencer giving two requesters serialised access to ram8
module ram8_arbiter
  import ram8_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  ram8_arbiter_if.slave     bus,
  output logic [DATA_W-1:0] mem_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
);
  state_t state;
  logic   ptr, valid, winner;
  rr_pick2 u_pick (.req0(bus.req0), .req1(bus.req1), .ptr, .valid, .winner);
  assign bus.busy = state != IDLE;
  // mem_addr/mem_in/mem_load double as the latched command; mem_load carries we through ACCESS
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      bus.gnt_id <= 1'b0;
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      bus.rdata  <= '0;
      mem_in     <= '0;
      mem_addr   <= '0;
      mem_load   <= 1'b0;
    end else
      case (state)
        IDLE: if (valid) begin
          state      <= ACCESS;
          bus.gnt_id <= winner;
          mem_load   <= winner ? bus.we1 : bus.we0;
          mem_addr   <= winner ? bus.addr1 : bus.addr0;
          mem_in     <= winner ? bus.wdata1 : bus.wdata0;
        end
        ACCESS: begin
          state    <= ACK;
          if (!mem_load) bus.rdata <= mem_out;
          mem_load <= 1'b0;
          bus.ack0 <= !bus.gnt_id;
          bus.ack1 <= bus.gnt_id;
        end
        ACK: begin
          state    <= IDLE;
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
          ptr      <= !bus.gnt_id;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_ram8_arbiter.sv
// tb_ram8_arbiter: directed scenarios plus random traffic against a transaction-level model
module tb_ram8_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] mem_in, mem_out;
  logic [2:0]  mem_addr;
  logic        mem_load;
  int          n_chk = 0, n_fail = 0;
  ram8_arbiter_if bus ();
  ram8_arbiter dut (.clk, .rst_n, .bus(bus.slave), .mem_in, .mem_addr, .mem_load, .mem_out);
  ram8 u_ram (.clk, .load(mem_load), .addr(mem_addr), .data(mem_in), .q(mem_out));
  always #5 clk = ~clk;

  int          busy_left = 0;
  logic        m_ptr = 1'b0, cur = 1'b0, cur_we = 1'b0;
  logic [2:0]  cur_addr = '0;
  logic [15:0] cur_data = '0, m_rdata = '0;
  logic [15:0] m_mem [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int id, input logic r, input logic w, input logic [2:0] a, input logic [15:0] d);
    if (id == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  // one clock: advance the transaction model using the inputs seen at the edge, then compare
  task automatic step();
    logic w;
    @(posedge clk); #1;
    if (busy_left == 0 && (bus.req0 || bus.req1)) begin
      w         = (bus.req0 && bus.req1) ? m_ptr : bus.req1;
      m_ptr     = !w;
      cur       = w;
      cur_we    = w ? bus.we1 : bus.we0;
      cur_addr  = w ? bus.addr1 : bus.addr0;
      cur_data  = w ? bus.wdata1 : bus.wdata0;
      busy_left = 2;
    end else if (busy_left != 0) busy_left--;
    if (busy_left == 1) begin
      if (cur_we) m_mem[cur_addr] = cur_data;
      else m_rdata = m_mem[cur_addr];
    end
    chk("ack0", bus.ack0, busy_left == 1 && !cur);
    chk("ack1", bus.ack1, busy_left == 1 && cur);
    chk("busy", bus.busy, busy_left != 0);
    chk("mem_load", mem_load, busy_left == 2 && cur_we);
    chk("gnt_id", bus.gnt_id, cur);
    chk("rdata", bus.rdata, m_rdata);
    if (busy_left != 0) chk("mem_addr", mem_addr, cur_addr);
    if (busy_left == 2 && cur_we) chk("mem_in", mem_in, cur_data);
  endtask

  task automatic wait_ack(output int id, output int lat);
    id = -1; lat = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      lat = i + 1;
      if (bus.ack0 || bus.ack1) begin
        id = bus.ack1 ? 1 : 0;
        return;
      end
    end
    chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic xact(input int id, input logic w, input logic [2:0] a, input logic [15:0] d, output int lat);
    int got;
    drive(id, 1'b1, w, a, d);
    wait_ack(got, lat);
    chk("xact_id", got, id);
    drive(id, 1'b0, 1'b0, 3'd0, 16'd0);
  endtask

  initial begin
    int id, lat;
    drive(0, 1'b0, 1'b0, 3'd0, 16'd0);
    drive(1, 1'b0, 1'b0, 3'd0, 16'd0);
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_load", mem_load, 1'b0);
    chk("rst_rdata", bus.rdata, 16'd0);
    chk("rst_gnt", bus.gnt_id, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single write then read-back by the other requester
    drive(0, 1'b1, 1'b1, 3'd5, 16'h1234);
    step();
    chk("t1_load", mem_load, 1'b1);
    chk("t1_addr", mem_addr, 3'd5);
    wait_ack(id, lat);
    chk("t1_id", id, 0);
    chk("t1_lat", lat, 1);
    drive(0, 1'b0, 1'b0, 3'd0, 16'd0);
    xact(1, 1'b0, 3'd5, 16'd0, lat);
    chk("t2_rdata", bus.rdata, 16'h1234);

    // contention with both requests held: grants alternate starting at 0
    drive(0, 1'b1, 1'b1, 3'd0, 16'h00AA);
    drive(1, 1'b1, 1'b1, 3'd7, 16'hFFFF);
    for (int k = 0; k < 4; k++) begin
      wait_ack(id, lat);
      chk("t3_seq", id, k % 2);
      chk("t3_excl", bus.ack0 & bus.ack1, 1'b0);
    end
    drive(0, 1'b0, 1'b0, 3'd0, 16'd0);
    drive(1, 1'b0, 1'b0, 3'd0, 16'd0);
    xact(0, 1'b0, 3'd0, 16'd0, lat);
    chk("t3_rd0", bus.rdata, 16'h00AA);
    xact(1, 1'b0, 3'd7, 16'd0, lat);
    chk("t3_rd7", bus.rdata, 16'hFFFF);

    // lone requester keeps winning even though priority toggles
    drive(0, 1'b1, 1'b1, 3'd2, 16'h0202);
    for (int k = 0; k < 3; k++) begin
      wait_ack(id, lat);
      chk("t4_id", id, 0);
    end
    drive(0, 1'b0, 1'b0, 3'd0, 16'd0);
    repeat (2) step();

    // reset during an ACCESS write aborts it
    drive(0, 1'b1, 1'b1, 3'd5, 16'hBEEF);
    step();
    chk("t5_pre_load", mem_load, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_load", mem_load, 1'b0);
    chk("t5_busy", bus.busy, 1'b0);
    chk("t5_ack", {bus.ack0, bus.ack1}, 2'b00);
    chk("t5_rdata", bus.rdata, 16'd0);
    busy_left = 0; m_ptr = 1'b0; cur = 1'b0; m_rdata = '0;
    drive(0, 1'b0, 1'b0, 3'd0, 16'd0);
    @(negedge clk) rst_n = 1'b1;
    xact(1, 1'b0, 3'd5, 16'd0, lat);
    chk("t5_keep", bus.rdata, 16'h1234);

    // request arriving during ACCESS waits for the next IDLE
    drive(0, 1'b1, 1'b1, 3'd3, 16'h3333);
    step();
    drive(1, 1'b1, 1'b0, 3'd3, 16'd0);
    wait_ack(id, lat);
    chk("t6_first", id, 0);
    drive(0, 1'b0, 1'b0, 3'd0, 16'd0);
    wait_ack(id, lat);
    chk("t6_second", id, 1);
    chk("t6_lat", lat, 3);
    chk("t6_rdata", bus.rdata, 16'h3333);
    drive(1, 1'b0, 1'b0, 3'd0, 16'd0);

    // fill every word so random reads have defined expectations
    for (int a = 0; a < 8; a++) xact(a % 2, 1'b1, 3'(a), 16'($urandom), lat);

    for (int c = 0; c < 400; c++) begin
      step();
      for (int r = 0; r < 2; r++) begin
        logic rq, ak;
        rq = r ? bus.req1 : bus.req0;
        ak = r ? bus.ack1 : bus.ack0;
        if (ak) drive(r, 1'($urandom_range(1)), 1'($urandom_range(1)), 3'($urandom), 16'($urandom));
        else if (!rq && $urandom_range(9) < 4)
          drive(r, 1'b1, 1'($urandom_range(1)), 3'($urandom), 16'($urandom));
      end
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
